// File: rtl/seg7_reader_if.sv
// Result channel of the segment reader: decoded code/class/dp with valid/ready.
// master drives the result; slave consumes it and returns ready.
interface seg7_reader_if;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_code;
    logic [1:0] out_kind;
    logic       out_dp;

    modport master (
        output out_valid,
        output out_code,
        output out_kind,
        output out_dp,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_code,
        input  out_kind,
        input  out_dp,
        output out_ready
    );
endinterface

// File: rtl/seg7_reader.sv
// Purpose: filter a 7-segment bus for stability, decode it, buffer one result.
// Latency: out_valid rises the cycle after a pattern's STABLE_CYCLES+1th sample.
// Backpressure: one-entry buffer; accepts arriving while full are dropped and counted.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int DROP_W        = 8
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic [7:0]        seg_in,
    seg7_reader_if.master     out_if,
    output logic              overrun,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef struct packed {
        logic [3:0] code;
        logic [1:0] kind;
        logic       dp;
    } result_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_M1  = 8'(STABLE_CYCLES - 1);

    logic [7:0] seg_q;
    logic [7:0] cnt;
    logic       seg_same;
    logic       accept;
    result_t    dec;
    result_t    res_q;
    state_t     state;
    logic       valid_q;

    assign seg_same = (seg_in == seg_q);
    // cnt passes STABLE_M1 only once per run, so each stable run accepts once.
    assign accept   = seg_same && (cnt == STABLE_M1) &&
                      ((seg_in[6:0] != 7'h00) || seg_in[7]);

    always_ff @(posedge clk_2) begin
        if (reset) begin
            seg_q <= 8'h00;
            cnt   <= 8'h00;
        end else begin
            seg_q <= seg_in;
            if (!seg_same) begin
                cnt <= 8'h00;
            end else if (cnt < STABLE_MAX) begin
                cnt <= cnt + 8'h01;
            end
        end
    end

    always_comb begin
        dec.code = 4'h0;
        dec.kind = 2'd3;
        dec.dp   = 1'b0;
        case (seg_in[6:0])
            7'h3F: begin dec.code = 4'h0; dec.kind = 2'd0; end
            7'h06: begin dec.code = 4'h1; dec.kind = 2'd0; end
            7'h5B: begin dec.code = 4'h2; dec.kind = 2'd0; end
            7'h4F: begin dec.code = 4'h3; dec.kind = 2'd0; end
            7'h66: begin dec.code = 4'h4; dec.kind = 2'd0; end
            7'h6D: begin dec.code = 4'h5; dec.kind = 2'd0; end
            7'h7D: begin dec.code = 4'h6; dec.kind = 2'd0; end
            7'h07: begin dec.code = 4'h7; dec.kind = 2'd0; end
            7'h7F: begin dec.code = 4'h8; dec.kind = 2'd0; end
            7'h67: begin dec.code = 4'h9; dec.kind = 2'd0; end
            7'h77: begin dec.code = 4'hA; dec.kind = 2'd1; end
            7'h73: begin dec.code = 4'hB; dec.kind = 2'd1; end
            7'h71: begin dec.code = 4'hF; dec.kind = 2'd1; end
            default: begin dec.code = 4'h0; dec.kind = 2'd3; end
        endcase
        if (dec.kind != 2'd3) begin
            dec.dp = seg_in[7];
        end else if (seg_in == 8'h80) begin
            dec.kind = 2'd2;
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state    <= IDLE;
            valid_q  <= 1'b0;
            res_q    <= '0;
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        res_q   <= dec;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_if.out_ready) begin
                        if (accept) begin
                            res_q <= dec;
                        end else begin
                            valid_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (accept) begin
                        // Buffered result wins; the newcomer is only counted.
                        overrun <= 1'b1;
                        if (drop_cnt != '1) begin
                            drop_cnt <= drop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_code  = res_q.code;
    assign out_if.out_kind  = res_q.kind;
    assign out_if.out_dp    = res_q.dp;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with STABLE_CYCLES=4, DROP_W=8.
module tb_seg7_reader;
    logic       clk_2 = 1'b0;
    logic       reset;
    logic [7:0] seg_in;
    logic       overrun;
    logic [7:0] drop_cnt;
    int         checks   = 0;
    int         failures = 0;

    seg7_reader_if sif();

    seg7_reader #(
        .STABLE_CYCLES(4),
        .DROP_W(8)
    ) dut (
        .clk_2(clk_2),
        .reset(reset),
        .seg_in(seg_in),
        .out_if(sif),
        .overrun(overrun),
        .drop_cnt(drop_cnt)
    );

    always #5 clk_2 = ~clk_2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_2);
            #1;
        end
    endtask

    // Packs {valid, code, kind, dp} for single-comparison result checks.
    function automatic logic [31:0] res(input logic v, input logic [3:0] c,
                                        input logic [1:0] k, input logic d);
        return {24'h0, v, c, k, d};
    endfunction

    function automatic logic [31:0] obs();
        return {24'h0, sif.out_valid, sif.out_code, sif.out_kind, sif.out_dp};
    endfunction

    initial begin
        int vcnt;
        int first;
        logic [31:0] cap;

        reset         = 1'b1;
        seg_in        = 8'h00;
        sif.out_ready = 1'b1;
        tick(2);
        chk("rst_out", obs(), res(0, 4'h0, 2'd0, 0));
        chk("rst_ovr", 32'(overrun), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        reset = 1'b0;

        // Single digit, downstream always ready: one-cycle valid pulse at cycle 5.
        seg_in = 8'h5B;
        vcnt = 0; first = 0; cap = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (sif.out_valid) begin
                vcnt++;
                if (first == 0) begin
                    first = i;
                    cap   = obs();
                end
            end
        end
        chk("t1_pulses", 32'(vcnt), 1);
        chk("t1_first", 32'(first), 5);
        chk("t1_res", cap, res(1, 4'h2, 2'd0, 0));

        // Pattern toggling every 2 cycles never becomes stable.
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            seg_in = (i % 2 == 0) ? 8'h06 : 8'h4F;
            for (int j = 0; j < 2; j++) begin
                tick(1);
                if (sif.out_valid) vcnt++;
            end
        end
        chk("t2_novalid", 32'(vcnt), 0);

        // Letter A with dp, held under backpressure, then drained.
        sif.out_ready = 1'b0;
        seg_in = 8'hF7;
        tick(5);
        chk("t3_load", obs(), res(1, 4'hA, 2'd1, 1));
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("t3_hold", obs(), res(1, 4'hA, 2'd1, 1));
        end
        sif.out_ready = 1'b1;
        tick(1);
        sif.out_ready = 1'b0;
        chk("t3_drain", obs(), res(0, 4'hA, 2'd1, 1));

        // Overrun: first result stays buffered, later accepts are counted.
        seg_in = 8'h00;
        tick(2);
        seg_in = 8'h66;
        tick(6);
        chk("t4_load", obs(), res(1, 4'h4, 2'd0, 0));
        chk("t4_ovr0", 32'(overrun), 0);
        seg_in = 8'h6D;
        tick(6);
        chk("t4_keep", obs(), res(1, 4'h4, 2'd0, 0));
        chk("t4_ovr1", 32'(overrun), 1);
        chk("t4_drop1", 32'(drop_cnt), 1);
        for (int i = 0; i < 300; i++) begin
            seg_in = (i % 2 == 0) ? 8'h66 : 8'h6D;
            tick(6);
        end
        chk("t4_sat", 32'(drop_cnt), 255);
        chk("t4_keep2", obs(), res(1, 4'h4, 2'd0, 0));
        chk("t4_sticky", 32'(overrun), 1);
        sif.out_ready = 1'b1;
        tick(1);
        chk("t4_drain", 32'(sif.out_valid), 0);

        // Classes: error indicator, invalid, digit with dp, letter P, blank.
        seg_in = 8'h80;
        tick(5);
        chk("t5_err", obs(), res(1, 4'h0, 2'd2, 0));
        seg_in = 8'h55;
        tick(5);
        chk("t5_inv", obs(), res(1, 4'h0, 2'd3, 0));
        seg_in = 8'hE7;
        tick(5);
        chk("t5_dig9dp", obs(), res(1, 4'h9, 2'd0, 1));
        seg_in = 8'h73;
        tick(5);
        chk("t5_letP", obs(), res(1, 4'hB, 2'd1, 0));
        seg_in = 8'h00;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (sif.out_valid) vcnt++;
        end
        chk("t5_blank", 32'(vcnt), 0);

        // Reset mid-transfer with a partial count, then re-accept of same pattern.
        sif.out_ready = 1'b0;
        seg_in = 8'h07;
        tick(5);
        chk("t6_load", obs(), res(1, 4'h7, 2'd0, 0));
        seg_in = 8'h7F;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_rst_out", obs(), res(0, 4'h0, 2'd0, 0));
        chk("t6_rst_ovr", 32'(overrun), 0);
        chk("t6_rst_drop", 32'(drop_cnt), 0);
        first = 0; cap = 0;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            if (sif.out_valid && first == 0) begin
                first = i;
                cap   = obs();
            end
        end
        chk("t6_first", 32'(first), 5);
        chk("t6_res", cap, res(1, 4'h8, 2'd0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
- Decoder/receiver counterpart to the 7-segment display encoder driving SEG.
- Samples an 8-bit segment bus (SEG[0]=a … SEG[6]=g, SEG[7]=dp), waits until the pattern is stable, decodes it back to a 4-bit code with a class tag, and hands the result downstream over a valid/ready handshake through a one-entry buffer.
- Used for loopback checking of the display path and for reading panel patterns back into the datapath.

Parameters:
- STABLE_CYCLES, 4, number of extra consecutive equal samples required before a pattern is accepted; legal range 1..255.
- DROP_W, 8, width of the saturating dropped-pattern counter.

Ports:
- clk_2  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- seg_in  in  8  segment pattern under observation, bit0=a … bit6=g, bit7=dp.
- out_ready  in  1  downstream ready to take the current result.
- out_valid  out  1  buffer holds an untaken result.
- out_code  out  4  decoded code.
- out_kind  out  2  class: 0 = digit, 1 = letter, 2 = error indicator, 3 = invalid.
- out_dp  out  1  decimal point of the accepted pattern.
- overrun  out  1  sticky; set when an accepted pattern is dropped.
- drop_cnt  out  DROP_W  saturating count of dropped patterns.

Behaviour:

Reset:
- reset=1 at a clk_2 edge clears seg_q, cnt, out_valid, out_code, out_kind, out_dp, overrun and drop_cnt to 0. The FSM returns to IDLE.
- Reset mid-transfer discards the buffered result and any partial stability count.

Stability filter:
- seg_q <= seg_in every cycle.
- If seg_in != seg_q, then cnt <= 0.
- Else, if cnt < STABLE_CYCLES, then cnt <= cnt+1.
- Otherwise cnt holds (saturates).
- accept = (seg_in == seg_q) && (cnt == STABLE_CYCLES-1) && (seg_in[6:0] != 0 || seg_in[7]).
- Net effect: a pattern must be present for STABLE_CYCLES+1 consecutive samples.
- Exactly one accept per stable run. A change followed by a return to the same pattern is a new run and re-accepts.
- Pattern 0x00 (blank) never accepts.

Decode (combinational on seg_in[6:0], registered on load):
- Digits, out_kind 0:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4
  - 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x67→9
- Letters, out_kind 1:
  - 0x77 ('A')→0xA
  - 0x73 ('P')→0xB
  - 0x71 ('F')→0xF
- Digits and letters: out_dp = seg_in[7].
- Exactly 0x80 → out_kind 2, code 0, dp 0.
- Anything else → out_kind 3, code 0, dp 0.

Output FSM, two states:
- IDLE (out_valid=0):
  - accept → load decode, go to HOLD.
- HOLD (out_valid=1):
  - out_ready && !accept → go to IDLE; outputs keep last values.
  - out_ready && accept → load new decode, stay in HOLD (back-to-back).
  - !out_ready && accept → keep old result, set overrun, drop_cnt <= drop_cnt+1, saturating at all-ones.
  - !out_ready && !accept → hold.
- out_code, out_kind and out_dp stay stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises one cycle after the accept cycle.
- Transfer occurs on any edge where out_valid && out_ready.

Test Plan:
1. Reset, then hold seg_in=0x5B for 6 cycles (STABLE_CYCLES=4), out_ready=1 → out_valid high for exactly 1 cycle, starting 5 cycles after seg_in first sampled; out_code=2, out_kind=0, out_dp=0.
2. Toggle seg_in between 0x06 and 0x4F every 2 cycles for 20 cycles → out_valid never asserts; cnt never exceeds 1.
3. seg_in=0xF7 held with out_ready=0 → out_valid=1, out_code=0xA, out_kind=1, out_dp=1; outputs hold for 10 cycles, then one out_ready pulse → out_valid=0 next cycle.
4. With out_ready=0 and a result buffered, present 0x66 then 0x6D, each stable → first stays buffered (code 4); overrun=1, drop_cnt=1. Repeat 300 drops → drop_cnt=255.
5. seg_in=0x80 → out_kind=2, code 0. seg_in=0x55 → out_kind=3. seg_in=0x00 for 20 cycles → no out_valid.
6. Assert reset while out_valid=1 and cnt=2 → next cycle all outputs 0. Same pattern still present → re-accepted STABLE_CYCLES+1 cycles after reset release.
